// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding and
// register-address width.
package pipeline_hazard_ctrl_pkg;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      LD_STALL = 2'd2
   } hz_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hazard_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: memory-wait, load-use and branch/jump
// handling with stall and flush performance counters.
//
// state    | meaning
// RUN      | normal issue, hazard checks active
// MEM_WAIT | second and later cycles of a memory wait, everything frozen
// LD_STALL | extra load-use bubble cycles beyond the first
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = 2,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 3,
   parameter int CNT_W       = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [REG_ADDR_W*NUM_SRC-1:0] ifid_rs,
   input  logic [NUM_SRC-1:0]            ifid_rs_used,
   input  logic [REG_ADDR_W-1:0]         idex_rd,
   input  logic                          idex_memread,
   input  logic                          memReady,
   input  logic                          Jump,
   input  logic                          PCSrc,
   input  logic                          cnt_clr,
   output logic                          bubble_ifid,
   output logic                          bubble_idex,
   output logic                          bubble_exmem,
   output logic                          write_pc,
   output logic                          write_ifid,
   output logic                          write_idex,
   output logic                          write_exmem,
   output logic                          write_memwb,
   output logic [CNT_W-1:0]              stall_cnt,
   output logic [CNT_W-1:0]              flush_cnt
);
   localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);

   hz_state_t  r_state, w_state_nxt;
   logic [1:0] r_ld_cnt, w_ld_nxt;
   logic       r_pend, w_pend_nxt;
   logic       w_load_use;
   logic       w_flush;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= RUN;
         r_ld_cnt <= '0;
         r_pend   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ld_cnt <= w_ld_nxt;
         r_pend   <= w_pend_nxt;
      end
   end

   always_comb begin
      w_load_use = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (ifid_rs_used[k] && (ifid_rs[REG_ADDR_W*k +: REG_ADDR_W] == idex_rd))
            w_load_use = 1'b1;
      end
      w_load_use = w_load_use && idex_memread && (idex_rd != '0);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ld_nxt     = r_ld_cnt;
      w_pend_nxt   = r_pend;
      w_flush      = 1'b0;
      bubble_ifid  = 1'b0;
      bubble_idex  = 1'b0;
      bubble_exmem = 1'b0;
      write_pc     = 1'b1;
      write_ifid   = 1'b1;
      write_idex   = 1'b1;
      write_exmem  = 1'b1;
      write_memwb  = 1'b1;

      if (!reset) begin
         bubble_ifid  = 1'b1;
         bubble_idex  = 1'b1;
         bubble_exmem = 1'b1;
         write_pc     = 1'b0;
         write_ifid   = 1'b0;
         write_idex   = 1'b0;
         write_exmem  = 1'b0;
         write_memwb  = 1'b0;
      end else if (memReady && (PCSrc || r_pend)) begin
         // A resolved branch discards everything younger, including a load stall.
         w_flush      = 1'b1;
         bubble_ifid  = 1'b1;
         bubble_idex  = (FLUSH_DEPTH >= 2);
         bubble_exmem = (FLUSH_DEPTH >= 3);
         w_state_nxt  = RUN;
         w_ld_nxt     = '0;
         w_pend_nxt   = 1'b0;
      end else begin
         // Only reachable with PCSrc while memory is busy: remember it.
         w_pend_nxt = r_pend | PCSrc;
         case (r_state)
            LD_STALL: begin
               bubble_idex = 1'b1;
               write_ifid  = 1'b0;
               write_pc    = 1'b0;
               w_ld_nxt    = r_ld_cnt - 2'd1;
               if (r_ld_cnt <= 2'd1) w_state_nxt = RUN;
            end
            default: begin
               if (!memReady) begin
                  write_pc    = 1'b0;
                  write_idex  = 1'b0;
                  write_exmem = 1'b0;
                  if (r_state == MEM_WAIT) begin
                     write_ifid  = 1'b0;
                     write_memwb = 1'b0;
                  end
                  w_state_nxt = MEM_WAIT;
               end else if (w_load_use) begin
                  bubble_idex = 1'b1;
                  write_ifid  = 1'b0;
                  write_pc    = 1'b0;
                  w_ld_nxt    = LD_INIT;
                  w_state_nxt = (LOAD_LAT > 1) ? LD_STALL : RUN;
               end else begin
                  bubble_ifid = Jump;
                  w_state_nxt = RUN;
               end
            end
         endcase
      end
   end

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (~write_pc),
      .clr   (cnt_clr),
      .cnt   (stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (w_flush),
      .clr   (cnt_clr),
      .cnt   (flush_cnt)
   );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed
// corner sequences and a randomized run against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
   localparam int NUM_SRC     = 2;
   localparam int LOAD_LAT    = 2;
   localparam int FLUSH_DEPTH = 2;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [5*NUM_SRC-1:0] ifid_rs;
   logic [NUM_SRC-1:0]   ifid_rs_used;
   logic [4:0]           idex_rd;
   logic                 idex_memread, memReady, Jump, PCSrc, cnt_clr;
   logic                 bubble_ifid, bubble_idex, bubble_exmem;
   logic                 write_pc, write_ifid, write_idex, write_exmem, write_memwb;
   logic [CNT_W-1:0]     stall_cnt, flush_cnt;
   logic [4:0]           w_wr;
   logic [2:0]           w_bub;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   assign w_wr  = {write_pc, write_ifid, write_idex, write_exmem, write_memwb};
   assign w_bub = {bubble_ifid, bubble_idex, bubble_exmem};

   pipeline_hazard_ctrl #(
      .NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
      .idex_rd(idex_rd), .idex_memread(idex_memread), .memReady(memReady), .Jump(Jump),
      .PCSrc(PCSrc), .cnt_clr(cnt_clr), .bubble_ifid(bubble_ifid), .bubble_idex(bubble_idex),
      .bubble_exmem(bubble_exmem), .write_pc(write_pc), .write_ifid(write_ifid),
      .write_idex(write_idex), .write_exmem(write_exmem), .write_memwb(write_memwb),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic       mr, j, pc, mrd;
      logic [4:0] rd;
      logic [9:0] rs;
      logic [1:0] used;
      logic [2:0] bub;
      logic [4:0] wr;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic mr, input logic j, input logic pc, input logic mrd,
                         input logic [4:0] rd, input logic [9:0] rs, input logic [1:0] used,
                         input logic clr);
      memReady = mr; Jump = j; PCSrc = pc; idex_memread = mrd;
      idex_rd = rd; ifid_rs = rs; ifid_rs_used = used; cnt_clr = clr;
   endtask

   task automatic set_idle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
   endtask

   task automatic adv();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   task automatic chk_out(input string name, input logic [2:0] bub, input logic [4:0] wr);
      @(negedge clock);
      chk({name, "_bub"}, 32'(w_bub), 32'(bub));
      chk({name, "_wr"},  32'(w_wr),  32'(wr));
   endtask

   // Reference model: remaining extra load-stall cycles, frozen-memory flag,
   // pending branch and the two counters as plain integers.
   int m_ldleft, m_stall, m_flush;
   bit m_memwait, m_pend;

   task automatic model_reset();
      m_ldleft = 0; m_stall = 0; m_flush = 0; m_memwait = 0; m_pend = 0;
   endtask

   task automatic model_cycle(output logic [2:0] e_bub, output logic [4:0] e_wr,
                              output bit e_fl, output bit e_lu);
      e_lu = 0;
      for (int k = 0; k < NUM_SRC; k++)
         if (ifid_rs_used[k] && ifid_rs[5*k +: 5] == idex_rd) e_lu = 1;
      e_lu = e_lu && idex_memread && idex_rd != 0;
      e_fl = memReady && (PCSrc || m_pend);
      e_bub = 3'b000;
      e_wr  = 5'b11111;
      if (e_fl) e_bub = {1'b1, 1'(FLUSH_DEPTH >= 2), 1'(FLUSH_DEPTH >= 3)};
      else if (m_ldleft > 0) begin e_bub = 3'b010; e_wr = 5'b00111; end
      else if (!memReady) e_wr = m_memwait ? 5'b00000 : 5'b01001;
      else if (e_lu) begin e_bub = 3'b010; e_wr = 5'b00111; end
      else if (Jump) e_bub = 3'b100;
   endtask

   task automatic model_update(input logic [4:0] e_wr, input bit e_fl, input bit e_lu);
      if (e_fl) begin
         m_ldleft = 0; m_memwait = 0; m_pend = 0;
      end else begin
         m_pend = m_pend | PCSrc;
         if (m_ldleft > 0) m_ldleft--;
         else if (!memReady) m_memwait = 1;
         else begin
            m_memwait = 0;
            if (e_lu) m_ldleft = LOAD_LAT - 1;
         end
      end
      if (cnt_clr) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (!e_wr[4] && m_stall < CNT_MAX) m_stall++;
         if (e_fl && m_flush < CNT_MAX) m_flush++;
      end
   endtask

   initial begin
      logic [2:0] e_bub;
      logic [4:0] e_wr;
      bit         e_fl, e_lu;

      // mr j pc mrd rd rs{op1,op0} used | bub wr
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,5'd0,{5'd0,5'd0},2'b00, 3'b000,5'b11111};
      vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,5'd0,{5'd0,5'd0},2'b00, 3'b100,5'b11111};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,5'd5,{5'd3,5'd5},2'b11, 3'b010,5'b00111};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,5'd7,{5'd7,5'd2},2'b10, 3'b010,5'b00111};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,5'd0,{5'd0,5'd0},2'b11, 3'b000,5'b11111};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,5'd5,{5'd3,5'd5},2'b10, 3'b000,5'b11111};
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,5'd0,{5'd0,5'd0},2'b00, 3'b000,5'b01001};
      vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,5'd0,{5'd0,5'd0},2'b00, 3'b110,5'b11111};
      vecs[8]  = '{1'b1,1'b0,1'b1,1'b1,5'd5,{5'd3,5'd5},2'b11, 3'b110,5'b11111};
      vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,5'd5,{5'd3,5'd5},2'b01, 3'b010,5'b00111};
      vecs[10] = '{1'b0,1'b1,1'b0,1'b0,5'd0,{5'd0,5'd0},2'b00, 3'b000,5'b01001};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b1,5'd5,{5'd3,5'd5},2'b11, 3'b000,5'b01001};

      reset = 1'b0;
      set_idle();
      chk_out("reset", 3'b111, 5'b00000);
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
      adv();
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         pulse_reset();
         set_in(vecs[i].mr, vecs[i].j, vecs[i].pc, vecs[i].mrd, vecs[i].rd,
                vecs[i].rs, vecs[i].used, 1'b0);
         chk_out($sformatf("vec%0d", i), vecs[i].bub, vecs[i].wr);
         adv();
      end

      // Load-use with two-cycle latency
      pulse_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, {5'd3, 5'd5}, 2'b11, 1'b0);
      chk_out("lu_c1", 3'b010, 5'b00111);
      adv();
      chk_out("lu_c2", 3'b010, 5'b00111);
      adv();
      set_idle();
      chk_out("lu_c3", 3'b000, 5'b11111);
      adv();
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd2);

      // Memory wait of three cycles
      pulse_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
      chk_out("mw_c1", 3'b000, 5'b01001);
      adv();
      chk_out("mw_c2", 3'b000, 5'b00000);
      adv();
      chk_out("mw_c3", 3'b000, 5'b00000);
      adv();
      set_idle();
      chk_out("mw_c4", 3'b000, 5'b11111);
      adv();
      chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);

      // Branch taken while memory busy is applied once memory is ready
      pulse_reset();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
      chk_out("pf_c1", 3'b000, 5'b01001);
      adv();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
      chk_out("pf_c2", 3'b000, 5'b00000);
      adv();
      set_idle();
      chk_out("pf_c3", 3'b110, 5'b11111);
      adv();
      chk_out("pf_c4", 3'b000, 5'b11111);
      adv();
      chk("pf_flush_cnt", 32'(flush_cnt), 32'd1);

      // Branch during load stall wins
      pulse_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, {5'd3, 5'd5}, 2'b11, 1'b0);
      chk_out("pri_c1", 3'b010, 5'b00111);
      adv();
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, {5'd3, 5'd5}, 2'b11, 1'b0);
      chk_out("pri_c2", 3'b110, 5'b11111);
      adv();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
      chk_out("pri_c3", 3'b100, 5'b11111);
      adv();
      chk("pri_flush_cnt", 32'(flush_cnt), 32'd1);

      // Saturation, clear priority, reset mid-wait discarding pending flush
      pulse_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0, 2'b00, 1'b1);
      adv();
      chk("clr_prio_stall_cnt", 32'(stall_cnt), 32'd0);
      cnt_clr = 1'b0;
      for (int i = 0; i < 19; i++) adv();
      chk("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
      PCSrc = 1'b1;
      adv();
      reset = 1'b0;
      set_idle();
      chk_out("rst_mid", 3'b111, 5'b00000);
      chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
      reset = 1'b1;
      chk_out("rst_resume", 3'b000, 5'b11111);
      adv();
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

      // Randomized run against the reference model
      pulse_reset();
      model_reset();
      for (int n = 0; n < 400; n++) begin
         set_in(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)),
                {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 29) == 0));
         @(negedge clock);
         model_cycle(e_bub, e_wr, e_fl, e_lu);
         chk("rnd_bub", 32'(w_bub), 32'(e_bub));
         chk("rnd_wr",  32'(w_wr),  32'(e_wr));
         adv();
         model_update(e_wr, e_fl, e_lu);
         chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
         chk("rnd_flush_cnt", 32'(flush_cnt), 32'(m_flush));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
